// File: rtl/wash_panel.sv
// wash_panel: front-panel input controller for the washer.
// Debounces the mode and start buttons, holds the selected programme and its
// total time, requests a run from the wash controller over a req/ack handshake,
// and emits setup-stage digit codes for the scan4 display mux.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   on         power switch level; low forces OFF
//   bt_mode    raw mode button (asynchronous, active-high)
//   bt_start   raw start button (asynchronous, active-high)
//   start_ack  wash controller accepted the run
//   done       one-cycle pulse: wash controller finished
//   mode       selected programme
//   wash_time  programme time in seconds (binary)
//   start_req  run request, held until start_ack
//   d1,d2,d3,d0 digit codes (0-9 numeric, 10 = end code, 11 = blank)
//   setup_led  high while in IDLE
module wash_panel #(
  parameter int unsigned DEB_CYCLES = 2_000_000,
  parameter logic [7:0]  T_SPIN     = 8'd20,
  parameter logic [7:0]  T_SMALL    = 8'd60,
  parameter logic [7:0]  T_MED      = 8'd75,
  parameter logic [7:0]  T_LARGE    = 8'd90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       bt_mode,
  input  logic       bt_start,
  input  logic       start_ack,
  input  logic       done,
  output logic [1:0] mode,
  output logic [7:0] wash_time,
  output logic       start_req,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d0,
  output logic       setup_led
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);

  localparam logic [3:0] DigEnd   = 4'd10;
  localparam logic [3:0] DigBlank = 4'd11;

  typedef enum logic [2:0] {StOff, StIdle, StReq, StRun, StFin} state_e;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers. Index 0 = mode, 1 = start.
  // ---------------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q;
  logic [1:0]    press_q;
  logic [CW-1:0] cnt_q [2];

  assign raw = {bt_start, bt_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            deb_q[i]   <= sync2_q[i];
            cnt_q[i]   <= '0;
            // Pulse coincides with the debounced level going high.
            press_q[i] <= sync2_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          // Level agrees with accepted state: any partial count was a glitch.
          cnt_q[i] <= '0;
        end
      end
    end
  end

  logic p_mode, p_start;
  assign p_mode  = press_q[0];
  assign p_start = press_q[1];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] wt_q, wt_d;

  function automatic logic [7:0] time_of(input logic [1:0] m);
    unique case (m)
      2'b00:   time_of = T_SPIN;
      2'b01:   time_of = T_SMALL;
      2'b10:   time_of = T_MED;
      default: time_of = T_LARGE;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wt_d    = wt_q;
    if (!on) begin
      state_d = StOff;
      mode_d  = 2'b01;
      wt_d    = T_SMALL;
    end else begin
      unique case (state_q)
        StOff:  state_d = StIdle;
        StIdle: begin
          if (p_start) begin
            state_d = StReq;
          end else if (p_mode) begin
            mode_d = mode_q + 2'b01;
            wt_d   = time_of(mode_q + 2'b01);
          end
        end
        StReq:  if (start_ack) state_d = StRun;
        StRun:  if (done) state_d = StFin;
        StFin:  if (p_mode || p_start) state_d = StIdle;
        default: state_d = StOff;
      endcase
    end
  end

  // Binary to two BCD digits by comparison; wash_time never exceeds 99.
  logic [3:0] tens_d, units_d;
  always_comb begin
    tens_d = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (wt_d >= 8'(k * 10)) tens_d = 4'(k);
    end
    units_d = 4'(wt_d - 8'(tens_d) * 8'd10);
  end

  // Output registers are loaded from next-state values so every output is a
  // flop yet reflects a state change on the same edge the state changes.
  logic [3:0] d1_d, d2_d, d3_d, d0_d;
  always_comb begin
    d1_d = DigBlank;
    d2_d = DigBlank;
    d3_d = DigBlank;
    d0_d = DigBlank;
    unique case (state_d)
      StIdle, StReq, StRun: begin
        d1_d = {2'b00, mode_d};
        d3_d = tens_d;
        d0_d = units_d;
      end
      StFin: begin
        d1_d = DigEnd;
        d3_d = 4'd0;
        d0_d = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOff;
      mode_q    <= 2'b01;
      wt_q      <= T_SMALL;
      start_req <= 1'b0;
      setup_led <= 1'b0;
      d1        <= DigBlank;
      d2        <= DigBlank;
      d3        <= DigBlank;
      d0        <= DigBlank;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wt_q      <= wt_d;
      start_req <= (state_d == StReq);
      setup_led <= (state_d == StIdle);
      d1        <= d1_d;
      d2        <= d2_d;
      d3        <= d3_d;
      d0        <= d0_d;
    end
  end

  assign mode      = mode_q;
  assign wash_time = wt_q;

endmodule

// File: tb/tb_wash_panel.sv
module tb_wash_panel;

  logic       clk = 1'b0;
  logic       rst, on, bt_mode, bt_start, start_ack, done;
  logic [1:0] mode;
  logic [7:0] wash_time;
  logic       start_req, setup_led;
  logic [3:0] d1, d2, d3, d0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wash_panel #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .bt_mode   (bt_mode),
    .bt_start  (bt_start),
    .start_ack (start_ack),
    .done      (done),
    .mode      (mode),
    .wash_time (wash_time),
    .start_req (start_req),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d0        (d0),
    .setup_led (setup_led)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks the IDLE/REQ/RUN display and programme registers together.
  task automatic check_prog(input string tag, input int m, input int t);
    check({tag, ".mode"}, mode, m);
    check({tag, ".time"}, wash_time, t);
    check({tag, ".d1"}, d1, m);
    check({tag, ".d2"}, d2, 11);
    check({tag, ".d3"}, d3, t / 10);
    check({tag, ".d0"}, d0, t % 10);
  endtask

  task automatic check_blank(input string tag);
    check({tag, ".d1"}, d1, 11);
    check({tag, ".d2"}, d2, 11);
    check({tag, ".d3"}, d3, 11);
    check({tag, ".d0"}, d0, 11);
  endtask

  task automatic press_mode();
    bt_mode = 1'b1;
    repeat (10) @(negedge clk);
    bt_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_start();
    bt_start = 1'b1;
    repeat (10) @(negedge clk);
    bt_start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; on = 1'b0; bt_mode = 1'b0; bt_start = 1'b0;
    start_ack = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.mode", mode, 1);
    check("rst.time", wash_time, 60);
    check("rst.req", start_req, 0);
    check("rst.led", setup_led, 0);
    check_blank("rst");

    // Power on: OFF for one cycle, then IDLE
    rst = 1'b0;
    @(negedge clk);
    check("off.led", setup_led, 0);
    on = 1'b1;
    @(negedge clk);
    check("on.led", setup_led, 1);
    check_prog("on", 1, 60);

    // Mode cycling with wrap
    press_mode(); check_prog("m1", 2, 75);
    press_mode(); check_prog("m2", 3, 90);
    press_mode(); check_prog("m3", 0, 20);
    press_mode(); check_prog("m4", 1, 60);

    // Glitches: 2 high, 1 low, 3 high never reaches 4 consecutive
    bt_mode = 1'b1; repeat (2) @(negedge clk);
    bt_mode = 1'b0; @(negedge clk);
    bt_mode = 1'b1; repeat (3) @(negedge clk);
    bt_mode = 1'b0; repeat (10) @(negedge clk);
    check_prog("glitch", 1, 60);

    // Start handshake: request held until ack
    bt_start = 1'b1;
    repeat (10) @(negedge clk);
    check("req.held", start_req, 1);
    check("req.led", setup_led, 0);
    repeat (10) @(negedge clk);
    bt_start = 1'b0;
    repeat (10) @(negedge clk);
    check("req.still", start_req, 1);
    press_mode();
    check("req.modeign", mode, 1);
    start_ack = 1'b1;
    @(negedge clk);
    start_ack = 1'b0;
    check("ack.req", start_req, 0);
    check_prog("run", 1, 60);

    // Presses in RUN are ignored
    press_start();
    check("run.req", start_req, 0);
    press_mode();
    check_prog("run.ign", 1, 60);

    // Done -> FIN display
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("fin.d1", d1, 10);
    check("fin.d2", d2, 11);
    check("fin.d3", d3, 0);
    check("fin.d0", d0, 0);

    // Press in FIN -> IDLE, programme kept
    press_mode();
    check("fin2idle.led", setup_led, 1);
    check_prog("fin2idle", 1, 60);

    // on=0 during REQ
    press_mode(); check_prog("m5", 2, 75);
    press_start();
    check("req2.req", start_req, 1);
    on = 1'b0;
    @(negedge clk);
    check("offreq.req", start_req, 0);
    check("offreq.mode", mode, 1);
    check("offreq.time", wash_time, 60);
    check("offreq.led", setup_led, 0);
    check_blank("offreq");
    on = 1'b1;
    repeat (2) @(negedge clk);
    check("reon.led", setup_led, 1);

    // Asynchronous reset during REQ
    press_mode(); check_prog("m6", 2, 75);
    press_start();
    check("req3.req", start_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rstreq.req", start_req, 0);
    check("rstreq.mode", mode, 1);
    check("rstreq.time", wash_time, 60);
    check("rstreq.led", setup_led, 0);
    check_blank("rstreq");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst.led", setup_led, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
